// File: rtl/display_pkg.sv
// Shared constants and scan-state encoding for the 4-digit multiplexed display.
// Pure declarations: no latency and no backpressure.
package display_pkg;

  localparam int N_DIG = 4;
  localparam logic [N_DIG-1:0] ANODOS_OFF = 4'b1111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } estado_t;

  // Active-low one-cold enable for the digit selected by the scan state.
  function automatic logic [N_DIG-1:0] anodo_sel(input estado_t e);
    return ~(4'b0001 << e);
  endfunction

endpackage

// File: rtl/divisor_refresco.sv
// Refresh divider counting 0..DIV-1 while enabled; tick is combinational in the wrap cycle.
// No backpressure: habilitar=0 freezes the count and suppresses tick.
module divisor_refresco #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic habilitar,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] ULTIMO = W'(DIV - 1);

  logic [W-1:0] cuenta;

  assign tick = habilitar && (cuenta == ULTIMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta <= '0;
    end else if (habilitar) begin
      cuenta <= tick ? '0 : cuenta + W'(1);
    end
  end

endmodule

// File: rtl/barrido_display.sv
// Time-multiplexed scan of four latched hex nibbles onto one digit bus; outputs registered, 1-cycle latency.
// No backpressure: cargar loads every cycle it is high, habilitar=0 blanks and freezes the scan.
module barrido_display
  import display_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] valor,
  input  logic        cargar,
  input  logic        habilitar,
  input  logic        supr_ceros,
  output logic [3:0]  digito,
  output logic [3:0]  anodos
);

  logic [15:0] latch;
  estado_t     estado, estado_sig;
  logic        tick;
  logic        blanco;
  logic [3:0]  digito_sig;
  logic [3:0]  anodos_sig;

  divisor_refresco #(.DIV(DIV)) u_divisor (
    .clk       (clk),
    .rst       (rst),
    .habilitar (habilitar),
    .tick      (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch <= '0;
    end else if (cargar) begin
      latch <= valor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= DIG0;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    blanco     = 1'b0;
    digito_sig = latch[{estado, 2'b00} +: 4];
    anodos_sig = ANODOS_OFF;

    if (tick) begin
      case (estado)
        DIG0:    estado_sig = DIG1;
        DIG1:    estado_sig = DIG2;
        DIG2:    estado_sig = DIG3;
        default: estado_sig = DIG0;
      endcase
    end

    // A digit is a leading zero when it and every more significant nibble are zero.
    case (estado)
      DIG1:    blanco = (latch[15:4]  == 12'h000);
      DIG2:    blanco = (latch[15:8]  == 8'h00);
      DIG3:    blanco = (latch[15:12] == 4'h0);
      default: blanco = 1'b0;
    endcase

    if (habilitar && !(supr_ceros && blanco)) begin
      anodos_sig = anodo_sel(estado);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digito <= 4'h0;
      anodos <= ANODOS_OFF;
    end else begin
      digito <= digito_sig;
      anodos <= anodos_sig;
    end
  end

endmodule

// File: tb/tb_barrido_display.sv
// Directed bench for barrido_display with DIV=4: scan order, freeze, zero blanking,
// load/wrap coincidence, repeated loads and asynchronous reset.
module tb_barrido_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] valor;
  logic        cargar;
  logic        habilitar;
  logic        supr_ceros;
  logic [3:0]  digito;
  logic [3:0]  anodos;

  int checks = 0;
  int errors = 0;

  logic [3:0] an_sel [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  barrido_display #(.DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .valor      (valor),
    .cargar     (cargar),
    .habilitar  (habilitar),
    .supr_ceros (supr_ceros),
    .digito     (digito),
    .anodos     (anodos)
  );

  always #5 clk = ~clk;

  task automatic chequeo(input string tag, input logic [15:0] obs, input logic [15:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  task automatic ver(input string tag, input logic [3:0] an_esp, input logic [3:0] dg_esp);
    chequeo({tag, ".anodos"}, {12'h000, anodos}, {12'h000, an_esp});
    chequeo({tag, ".digito"}, {12'h000, digito}, {12'h000, dg_esp});
  endtask

  // Reset, load v with habilitar low, then enable: the j-th following negedge shows digit (j-1)/4.
  task automatic arrancar(input logic [15:0] v, input logic s);
    @(negedge clk);
    rst = 1'b1; habilitar = 1'b0; cargar = 1'b0;
    @(negedge clk);
    rst = 1'b0; valor = v; cargar = 1'b1; supr_ceros = s;
    @(negedge clk);
    cargar = 1'b0; habilitar = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chequeo("un_anodo", ($countones(~anodos) <= 1) ? 16'd1 : 16'd0, 16'd1);
    end
  end

  initial begin
    logic [15:0] v;
    logic [3:0]  an_blk [4];
    logic [3:0]  dg_blk [4];

    rst = 1'b1; habilitar = 1'b0; cargar = 1'b0; supr_ceros = 1'b0; valor = 16'h0000;
    @(negedge clk);
    ver("reset", 4'b1111, 4'h0);

    // Basic scan of A5D7.
    rst = 1'b0; valor = 16'hA5D7; cargar = 1'b1;
    @(negedge clk);
    ver("carga_sin_hab", 4'b1111, 4'h0);
    cargar = 1'b0; habilitar = 1'b1;
    v = 16'hA5D7;
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      ver($sformatf("scan%0d", j), an_sel[((j-1)/4)%4], v[4*(((j-1)/4)%4) +: 4]);
    end

    // Freeze in the first cycle of DIG2, then resume with the remaining dwell.
    arrancar(16'hA5D7, 1'b0);
    repeat (9) @(negedge clk);
    ver("pre_freeze", 4'b1011, 4'h5);
    habilitar = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chequeo($sformatf("freeze%0d.anodos", i), {12'h000, anodos}, 16'h000F);
    end
    habilitar = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ver($sformatf("resume%0d", i), 4'b1011, 4'h5);
    end
    @(negedge clk);
    ver("resume_dig3", 4'b0111, 4'hA);

    // Leading-zero suppression.
    an_blk = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    dg_blk = '{4'h0, 4'h5, 4'h0, 4'h0};
    arrancar(16'h0050, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      ver($sformatf("supr0050_%0d", j), an_blk[(j-1)/4], dg_blk[(j-1)/4]);
    end
    arrancar(16'h0000, 1'b1);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      ver($sformatf("supr0000_%0d", j), ((j-1)/4 == 0) ? 4'b1110 : 4'b1111, 4'h0);
    end

    // Load coinciding with the DIG0->DIG1 wrap, then back-to-back loads.
    arrancar(16'hA5D7, 1'b0);
    repeat (3) @(negedge clk);
    valor = 16'h1234; cargar = 1'b1;
    @(negedge clk);
    ver("wrap_old", 4'b1110, 4'h7);
    cargar = 1'b0;
    for (int j = 5; j <= 8; j++) begin
      @(negedge clk);
      ver($sformatf("wrap_new%0d", j), 4'b1101, 4'h3);
    end
    @(negedge clk);
    ver("wrap_dig2", 4'b1011, 4'h2);
    valor = 16'h1111; cargar = 1'b1;
    @(negedge clk);
    ver("multi10", 4'b1011, 4'h2);
    valor = 16'h2222;
    @(negedge clk);
    ver("multi11", 4'b1011, 4'h1);
    valor = 16'hBEEF;
    @(negedge clk);
    ver("multi12", 4'b1011, 4'h2);
    cargar = 1'b0;
    @(negedge clk);
    ver("multi13", 4'b0111, 4'hB);

    // Asynchronous reset between edges during DIG3.
    arrancar(16'hA5D7, 1'b0);
    repeat (13) @(negedge clk);
    ver("pre_rst", 4'b0111, 4'hA);
    #2 rst = 1'b1;
    #1 ver("rst_async", 4'b1111, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      ver($sformatf("post_rst%0d", j), 4'b1110, 4'h0);
    end
    @(negedge clk);
    ver("post_rst_dig1", 4'b1101, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrido_display.md
BARRIDO_DISPLAY -- requirements
Module: barrido_display

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles each digit stays lit (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset (one clock; reset is asynchronous and active-high).
REQ-004 SHALL have port valor, input, 16, four hex nibbles to display; nibble 0 = valor[3:0] = rightmost digit.
REQ-005 SHALL have port cargar, input, 1, single-cycle strobe that latches valor.
REQ-006 SHALL have port habilitar, input, 1, scan enable; low = display dark and scan frozen.
REQ-007 SHALL have port supr_ceros, input, 1, leading-zero suppression enable.
REQ-008 SHALL have port digito, output, 4, nibble for the downstream 7-segment decoder input.
REQ-009 SHALL have port anodos, output, 4, active-low digit enables; bit i lights digit i.

Function
REQ-010 SHALL hold a 16-bit latched register, loaded from valor in any cycle with cargar=1, regardless of habilitar.
REQ-011 SHALL run a refresh counter 0..DIV-1 that increments while habilitar=1 and wraps to 0 after DIV-1.
REQ-012 SHALL implement a 4-state scan FSM DIG0->DIG1->DIG2->DIG3->DIG0, advancing one state in each cycle in which the counter wraps.
REQ-013 SHALL hold counter and FSM state unchanged while habilitar=0.
REQ-014 SHALL register digito and anodos, so outputs reflect the state and latched register of the previous cycle (1-cycle latency).
REQ-015 SHALL drive digito = latched nibble selected by the current state (DIGi -> bits [4i+3:4i]).
REQ-016 SHALL drive anodos = 4'b1111 when habilitar=0, else all ones except bit i = 0 in state DIGi.
REQ-017 SHALL, when supr_ceros=1, blank (anodo bit = 1) digit i >= 1 if all latched nibbles i..3 are zero; digit 0 is never suppressed.
REQ-018 SHALL, when cargar coincides with a counter wrap, perform both; the next output shows the new digit index with the newly latched value.
REQ-019 SHALL treat cargar held high for several cycles as repeated loads; the last value wins.
REQ-020 SHALL never assert more than one anodos bit low in any cycle.

Reset
REQ-021 SHALL, while rst=1, force latched register = 0, counter = 0, state = DIG0, digito = 4'h0, anodos = 4'b1111, independent of clk.
REQ-022 SHALL, on rst deassertion mid-scan, restart at DIG0 with a full DIV-cycle dwell.

Structure
REQ-023 SHALL place the N_DIG=4 constant, the ANODOS_OFF=4'b1111 constant and the scan state enum typedef in shared package display_pkg.
REQ-024 SHALL implement the refresh counter as sub-module divisor_refresco (parameter DIV; ports clk, rst, habilitar, tick) with tick=1 in the wrap cycle.
REQ-025 SHALL keep digito directly connectable to the decoder's 4-bit input with no glue logic.

Verification (DIV=4)
REQ-026 SHALL cover: rst=1 -> digito=0000, anodos=1111; then habilitar=1, cargar with valor=16'hA5D7 -> anodos 1110/1101/1011/0111 each for 4 cycles, digito 7/D/5/A.
REQ-027 SHALL cover: habilitar=0 mid-DIG2 for 10 cycles -> anodos=1111; re-enable -> resumes in DIG2 with the remaining dwell.
REQ-028 SHALL cover: supr_ceros=1, valor=16'h0050 -> digits 2,3 never lit, digits 0,1 lit; valor=16'h0000 -> only digit 0 lit with digito=0.
REQ-029 SHALL cover: cargar in the wrap cycle from DIG0 with valor=16'h1234 -> the next output is anodos=1101, digito=3.
REQ-030 SHALL cover: rst pulse asserted between clock edges during DIG3 -> outputs reset immediately, scan restarts at DIG0.
REQ-031 SHALL check that anodos never has more than one zero bit (assertion over all scenarios).
